// File: rtl/wasca_trace_recorder_pkg.sv
// -----------------------------------------------------------------------------
// wasca_trace_pkg
// Shared types and constants for the bus-trace recorder.
//   state_t      : recorder control states
//   *_DEF        : default address / event / timestamp widths
//   MEM_WORDS    : depth of the trace memory fed by the recorder
//   pack_entry() : builds one 64-bit trace word {timestamp, event}
// -----------------------------------------------------------------------------
package wasca_trace_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int EVT_W_DEF  = 48;
  localparam int TS_W_DEF   = 16;
  localparam int WORD_W     = TS_W_DEF + EVT_W_DEF;
  localparam int MEM_WORDS  = 512;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Timestamp occupies the upper bits so a memory dump sorts naturally by time.
  function automatic logic [WORD_W-1:0] pack_entry(input logic [TS_W_DEF-1:0]  ts,
                                                   input logic [EVT_W_DEF-1:0] evt);
    return {ts, evt};
  endfunction

endpackage

// File: rtl/wasca_trace_recorder_fifo.sv
// -----------------------------------------------------------------------------
// wasca_trace_fifo
// Small synchronous skid FIFO between event capture and the trace memory
// write port. Head is combinational so the write port sees the oldest entry
// in the same cycle it becomes available.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wdata  : enqueue (ignored when full unless a pop happens too)
//   pop          : dequeue head (ignored when empty)
//   flush        : drop all entries; takes priority over push/pop
//   head         : oldest entry
//   full, empty  : status
//   occupancy    : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module wasca_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW:0]      occ_reg;
  logic             do_push;
  logic             do_pop;

  assign empty     = (occ_reg == '0);
  assign full      = (occ_reg == FULL_OCC);
  assign occupancy = occ_reg;
  assign head      = store[rd_ptr_reg];

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is reset so the write-data bus reads zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (do_push && !flush) begin
      store[wr_ptr_reg] <= wdata;
    end
  end

endmodule

// File: rtl/wasca_trace_recorder.sv
// -----------------------------------------------------------------------------
// wasca_trace_recorder
// Timestamps bus-trace events and writes them as {ts, event} words into the
// on-chip trace memory through an Avalon-MM write port.
//   clk, reset_n          : clock, asynchronous active-low reset
//   evt_valid, evt_data   : incoming trace event (max one per cycle)
//   ctrl_start/stop/clear : control pulses from the register block
//   ctrl_wrap             : 1 = circular buffer, 0 = stop when full
//   mem_*                 : Avalon write master into the trace memory
//   st_*                  : status back to the register block
// -----------------------------------------------------------------------------
module wasca_trace_recorder
  import wasca_trace_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int EVT_W      = EVT_W_DEF,
  parameter int TS_W       = TS_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                evt_valid,
  input  logic [EVT_W-1:0]    evt_data,
  input  logic                ctrl_start,
  input  logic                ctrl_stop,
  input  logic                ctrl_clear,
  input  logic                ctrl_wrap,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [7:0]          mem_byteenable,
  output logic [63:0]         mem_writedata,
  input  logic                mem_waitrequest,
  output logic                st_busy,
  output logic                st_done,
  output logic [ADDR_W-1:0]   st_wr_ptr,
  output logic [ADDR_W:0]     st_count,
  output logic                st_wrapped,
  output logic [15:0]         st_drops
);

  localparam int WORDS = 2**ADDR_W;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  state_t              state_reg;
  state_t              state_next;
  logic                wrap_reg;
  logic [TS_W-1:0]     ts_reg;
  logic [ADDR_W-1:0]   wr_ptr_reg;
  logic [ADDR_W:0]     count_reg;
  logic                wrapped_reg;
  logic [15:0]         drops_reg;

  logic [63:0]         fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [OCC_W-1:0]    fifo_occ;

  logic                wr_done;
  logic                start_cmd;
  logic                evt_seen;
  logic                evt_accept;
  logic                evt_drop;
  logic                mem_limit;
  logic [ADDR_W+1:0]   reserved;

  // Words already in memory plus words still queued; in stop-when-full mode
  // this must never exceed the memory depth.
  assign reserved  = {1'b0, count_reg} + (ADDR_W+2)'(fifo_occ);
  assign mem_limit = !wrap_reg && (reserved >= (ADDR_W+2)'(WORDS));

  assign wr_done   = mem_write && !mem_waitrequest;
  assign start_cmd = ctrl_start && !ctrl_clear &&
                     ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  // The clear cycle discards the incoming event outright: the FIFO is being
  // flushed, so neither an accept nor a drop would mean anything.
  assign evt_seen   = evt_valid && (state_reg == ST_CAPTURE) && !ctrl_clear;
  assign evt_accept = evt_seen && (!fifo_full || wr_done) && !mem_limit;
  assign evt_drop   = evt_seen && !evt_accept;

  wasca_trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (evt_accept),
    .wdata     (pack_entry(ts_reg, evt_data)),
    .pop       (wr_done),
    .flush     (ctrl_clear),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    if (ctrl_clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:    if (ctrl_start) state_next = ST_CAPTURE;
        ST_CAPTURE: if (ctrl_stop || mem_limit) state_next = ST_DRAIN;
        ST_DRAIN:   if (fifo_empty) state_next = ST_DONE;
        ST_DONE:    if (ctrl_start) state_next = ST_CAPTURE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    st_busy   = 1'b0;
    st_done   = 1'b0;
    mem_write = 1'b0;
    case (state_reg)
      ST_CAPTURE, ST_DRAIN: begin
        st_busy   = 1'b1;
        mem_write = !fifo_empty;
      end
      ST_DONE: st_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- datapath / status ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_reg    <= 1'b0;
      ts_reg      <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      wrapped_reg <= 1'b0;
      drops_reg   <= '0;
    end else if (start_cmd) begin
      wrap_reg    <= ctrl_wrap;
      ts_reg      <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      wrapped_reg <= 1'b0;
      drops_reg   <= '0;
    end else begin
      if (state_reg == ST_CAPTURE) ts_reg <= ts_reg + 1'b1;
      // A write completing in a clear cycle still lands in memory, so the
      // pointer tracks it regardless of ctrl_clear.
      if (wr_done) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (count_reg != (ADDR_W+1)'(WORDS)) count_reg <= count_reg + 1'b1;
        // Rolling over after exactly filling in stop mode overwrites nothing,
        // so only circular mode reports a wrap.
        if (wrap_reg && (wr_ptr_reg == '1)) wrapped_reg <= 1'b1;
      end
      if (evt_drop && (drops_reg != 16'hFFFF)) drops_reg <= drops_reg + 1'b1;
    end
  end

  assign mem_address    = wr_ptr_reg;
  assign mem_chipselect = mem_write;
  assign mem_byteenable = 8'hFF;
  assign mem_writedata  = fifo_head;

  assign st_wr_ptr  = wr_ptr_reg;
  assign st_count   = count_reg;
  assign st_wrapped = wrapped_reg;
  assign st_drops   = drops_reg;

endmodule

// File: tb/tb_wasca_trace_recorder.sv
// Directed bench: stimulus pushes expected writes into a scoreboard queue,
// a monitor pops and compares on every completed Avalon write.
module tb_wasca_trace_recorder;

  localparam int ADDR_W = 9;
  localparam int EVT_W  = 48;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                evt_valid = 1'b0;
  logic [EVT_W-1:0]    evt_data = '0;
  logic                ctrl_start = 1'b0;
  logic                ctrl_stop = 1'b0;
  logic                ctrl_clear = 1'b0;
  logic                ctrl_wrap = 1'b0;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_write;
  logic [7:0]          mem_byteenable;
  logic [63:0]         mem_writedata;
  logic                mem_waitrequest = 1'b0;
  logic                st_busy;
  logic                st_done;
  logic [ADDR_W-1:0]   st_wr_ptr;
  logic [ADDR_W:0]     st_count;
  logic                st_wrapped;
  logic [15:0]         st_drops;

  always #5 clk = ~clk;

  wasca_trace_recorder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .evt_valid       (evt_valid),
    .evt_data        (evt_data),
    .ctrl_start      (ctrl_start),
    .ctrl_stop       (ctrl_stop),
    .ctrl_clear      (ctrl_clear),
    .ctrl_wrap       (ctrl_wrap),
    .mem_address     (mem_address),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_waitrequest (mem_waitrequest),
    .st_busy         (st_busy),
    .st_done         (st_done),
    .st_wr_ptr       (st_wr_ptr),
    .st_count        (st_count),
    .st_wrapped      (st_wrapped),
    .st_drops        (st_drops)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [47:0] ev(input int tag, input int k);
    return {tag[7:0], 8'h00, k[31:0]};
  endfunction

  task automatic push_exp(input int addr, input int ts, input logic [47:0] evt);
    exp_t e;
    e.addr = addr[ADDR_W-1:0];
    e.data = {ts[15:0], evt};
    sb_q.push_back(e);
  endtask

  task automatic do_start(input logic wrap);
    ctrl_start = 1'b1;
    ctrl_wrap  = wrap;
    tick();
    ctrl_start = 1'b0;
    ctrl_wrap  = 1'b0;
  endtask

  task automatic pulse_clear();
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (st_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (st_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: st_done=%b after %0d cycles, required 1", name, st_done, n);
    end
  endtask

  // Monitor: every completed write must match the oldest expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && mem_write && !mem_waitrequest) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: addr %0d data %h, required no write",
                   mem_address, mem_writedata);
        end else begin
          e = sb_q.pop_front();
          if (mem_address !== e.addr || mem_writedata !== e.data ||
              mem_chipselect !== 1'b1 || mem_byteenable !== 8'hFF) begin
            miscompares++;
            $display("FAIL write: addr %0d data %h cs %b be %h, required addr %0d data %h cs 1 be ff",
                     mem_address, mem_writedata, mem_chipselect, mem_byteenable, e.addr, e.data);
          end else begin
            $display("write addr=%0d data=%h", mem_address, mem_writedata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // ---------------- reset ----------------
    tick();
    tick();
    check("rst_mem_write",  64'(mem_write), 64'd0);
    check("rst_byteenable", 64'(mem_byteenable), 64'hFF);
    check("rst_address",    64'(mem_address), 64'd0);
    check("rst_writedata",  mem_writedata, 64'd0);
    check("rst_busy",       64'(st_busy), 64'd0);
    check("rst_count",      64'(st_count), 64'd0);
    check("rst_drops",      64'(st_drops), 64'd0);
    reset_n = 1'b1;
    tick();

    // ---------------- 1: three events, first-word latency ----------------
    do_start(1'b0);
    for (int k = 0; k < 3; k++) begin
      evt_valid = 1'b1;
      evt_data  = ev(1, k);
      push_exp(k, k, ev(1, k));
      if (k == 0) check("t1_no_write_same_cycle", 64'(mem_write), 64'd0);
      if (k == 1) begin
        check("t1_write_next_cycle", 64'(mem_write), 64'd1);
        check("t1_first_addr", 64'(mem_address), 64'd0);
      end
      tick();
    end
    evt_valid = 1'b0;
    tick(); tick(); tick();
    check("t1_count",  64'(st_count), 64'd3);
    check("t1_wr_ptr", 64'(st_wr_ptr), 64'd3);
    check("t1_busy",   64'(st_busy), 64'd1);
    ctrl_stop = 1'b1;
    tick();
    ctrl_stop = 1'b0;
    wait_done("t1");
    pulse_clear();
    ctrl_stop = 1'b1;           // stop in IDLE must be ignored
    tick();
    ctrl_stop = 1'b0;
    check("t1_idle_stop_busy", 64'(st_busy), 64'd0);
    check("t1_idle_stop_done", 64'(st_done), 64'd0);

    // ---------------- 2: stop-when-full, 600 events ----------------
    // Event k is accepted in capture cycle k for k < 512. In cycle 512 the
    // memory is fully reserved, so that event is the single drop; the
    // recorder is in DRAIN from cycle 513 and ignores the rest.
    do_start(1'b0);
    for (int k = 0; k < 600; k++) begin
      evt_valid = 1'b1;
      evt_data  = ev(2, k);
      if (k < 512) push_exp(k, k, ev(2, k));
      tick();
    end
    evt_valid = 1'b0;
    tick();
    check("t2_done",    64'(st_done), 64'd1);
    check("t2_count",   64'(st_count), 64'd512);
    check("t2_wr_ptr",  64'(st_wr_ptr), 64'd0);
    check("t2_drops",   64'(st_drops), 64'd1);
    check("t2_wrapped", 64'(st_wrapped), 64'd0);
    pulse_clear();

    // ---------------- 3: circular, 520 events, stray start ignored ----------------
    do_start(1'b1);
    for (int k = 0; k < 520; k++) begin
      evt_valid  = 1'b1;
      evt_data   = ev(3, k);
      ctrl_start = (k == 100);
      push_exp(k % 512, k, ev(3, k));
      tick();
    end
    evt_valid  = 1'b0;
    ctrl_start = 1'b0;
    tick(); tick();
    check("t3_wr_ptr",  64'(st_wr_ptr), 64'd8);
    check("t3_count",   64'(st_count), 64'd512);
    check("t3_wrapped", 64'(st_wrapped), 64'd1);
    check("t3_drops",   64'(st_drops), 64'd0);
    ctrl_stop = 1'b1;
    tick();
    ctrl_stop = 1'b0;
    wait_done("t3");
    pulse_clear();

    // ---------------- 4: 10-cycle stall during a 10-event burst ----------------
    do_start(1'b0);
    mem_waitrequest = 1'b1;
    for (int k = 0; k < 10; k++) begin
      evt_valid = 1'b1;
      evt_data  = ev(4, k);
      if (k < 4) push_exp(k, k, ev(4, k));
      if (k == 5 || k == 9) begin
        check("t4_stall_write", 64'(mem_write), 64'd1);
        check("t4_stall_addr",  64'(mem_address), 64'd0);
        check("t4_stall_data",  mem_writedata, {16'd0, ev(4, 0)});
      end
      tick();
    end
    evt_valid = 1'b0;
    mem_waitrequest = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t4_drops", 64'(st_drops), 64'd6);
    check("t4_count", 64'(st_count), 64'd4);
    ctrl_stop = 1'b1;
    tick();
    ctrl_stop = 1'b0;
    wait_done("t4");
    pulse_clear();

    // ---------------- 5: stop with 3 queued, toggling waitrequest ----------------
    do_start(1'b0);
    mem_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      evt_valid = 1'b1;
      evt_data  = ev(5, k);
      push_exp(k, k, ev(5, k));
      tick();
    end
    evt_valid = 1'b0;
    ctrl_stop = 1'b1;
    tick();
    ctrl_stop = 1'b0;
    evt_valid = 1'b1;            // events during DRAIN must be ignored
    evt_data  = ev(5, 99);
    check("t5_drain_busy", 64'(st_busy), 64'd1);
    n = 0;
    while (st_done !== 1'b1 && n < 100) begin
      mem_waitrequest = n[0];
      tick();
      n++;
    end
    check("t5_done", 64'(st_done), 64'd1);
    evt_valid = 1'b0;
    mem_waitrequest = 1'b0;
    check("t5_count", 64'(st_count), 64'd3);
    check("t5_drops", 64'(st_drops), 64'd0);
    pulse_clear();

    // ---------------- 6a: clear mid-capture (with simultaneous start) ----------------
    do_start(1'b0);
    mem_waitrequest = 1'b1;
    for (int k = 0; k < 2; k++) begin
      evt_valid = 1'b1;
      evt_data  = ev(6, k);
      tick();
    end
    evt_valid  = 1'b0;
    ctrl_clear = 1'b1;
    ctrl_start = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    ctrl_start = 1'b0;
    check("t6_clear_busy",  64'(st_busy), 64'd0);
    check("t6_clear_write", 64'(mem_write), 64'd0);
    check("t6_clear_done",  64'(st_done), 64'd0);
    mem_waitrequest = 1'b0;
    tick(); tick(); tick();
    check("t6_clear_count", 64'(st_count), 64'd0);
    // A fresh capture must see an empty FIFO: its first word is the new event.
    do_start(1'b0);
    evt_valid = 1'b1;
    evt_data  = ev(6, 50);
    push_exp(0, 0, ev(6, 50));
    tick();
    evt_valid = 1'b0;
    tick(); tick();
    check("t6_restart_count", 64'(st_count), 64'd1);

    // ---------------- 6b: asynchronous reset mid-capture ----------------
    mem_waitrequest = 1'b1;
    evt_valid = 1'b1;
    evt_data  = ev(7, 0);
    tick();
    evt_valid = 1'b0;
    check("t6_pre_reset_write", 64'(mem_write), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_write", 64'(mem_write), 64'd0);
    check("t6_async_busy",  64'(st_busy), 64'd0);
    check("t6_async_count", 64'(st_count), 64'd0);
    check("t6_async_addr",  64'(mem_address), 64'd0);
    check("t6_async_data",  mem_writedata, 64'd0);
    tick();
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    tick(); tick();

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
